// File: rtl/ucaspian_pkg.sv
// ---------------------------------------------------------------------------
// ucaspian_pkg
// Shared types and helpers for the charge accumulation datapath.
//   CHARGE_W_DEFAULT : default stored charge width
//   EV_CHARGE_W      : width of a signed charge event from the dendrite mux
//   op_kind_e        : pipeline op kind (accumulate / read-and-clear)
//   accum_state_e    : accumulator FSM states
//   sat_add          : saturating signed add of an event into a stored charge
// ---------------------------------------------------------------------------
package ucaspian_pkg;

  localparam int unsigned CHARGE_W_DEFAULT = 16;
  localparam int unsigned EV_CHARGE_W      = 9;

  typedef enum logic {
    OP_ACC,
    OP_RD
  } op_kind_e;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } accum_state_e;

  // Add a sign-extended event to a stored charge, clamping to the
  // representable range instead of wrapping.
  function automatic logic signed [CHARGE_W_DEFAULT-1:0] sat_add(
    input logic signed [CHARGE_W_DEFAULT-1:0] old_val,
    input logic signed [EV_CHARGE_W-1:0]      inc
  );
    logic signed [CHARGE_W_DEFAULT:0] sum;
    sum = {old_val[CHARGE_W_DEFAULT-1], old_val}
        + {{(CHARGE_W_DEFAULT + 1 - EV_CHARGE_W){inc[EV_CHARGE_W-1]}}, inc};
    // Top two bits disagree only when the result left the narrow range.
    if (sum[CHARGE_W_DEFAULT] != sum[CHARGE_W_DEFAULT-1]) begin
      if (sum[CHARGE_W_DEFAULT]) begin
        return {1'b1, {(CHARGE_W_DEFAULT-1){1'b0}}};
      end else begin
        return {1'b0, {(CHARGE_W_DEFAULT-1){1'b1}}};
      end
    end
    return sum[CHARGE_W_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/dendrite_accum_charge_ram.sv
// ---------------------------------------------------------------------------
// charge_ram
// Simple dual-port per-neuron charge memory, synchronous read. A read of the
// address being written in the same cycle returns the old contents.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (registered)
//   rdata  : read data, valid the cycle after raddr is presented
// ---------------------------------------------------------------------------
module charge_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dendrite_accum.sv
// ---------------------------------------------------------------------------
// dendrite_accum
// Accumulates signed charge events into a per-neuron charge memory with
// saturation, serves read-and-clear requests, and sweeps the memory to zero
// after reset or on command.
//   clk            : clock
//   reset_n        : asynchronous active-low reset
//   dend_addr      : target neuron of a charge event
//   dend_charge    : signed charge increment
//   dend_vld/rdy   : event handshake
//   nrn_rd_addr    : neuron to read-and-clear
//   nrn_rd_vld/rdy : read request handshake (reads win over events)
//   nrn_charge     : charge returned by a read
//   nrn_charge_vld : one-cycle strobe, two cycles after the read is accepted
//   clear_start    : pulse to zero the whole memory
//   clear_busy     : high while the memory sweep is active
//   clear_done     : one-cycle pulse when the sweep finishes
// ---------------------------------------------------------------------------
module dendrite_accum
  import ucaspian_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 256,
  parameter int unsigned CHARGE_W    = CHARGE_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 dend_addr,
  input  logic signed [8:0]          dend_charge,
  input  logic                       dend_vld,
  output logic                       dend_rdy,
  input  logic [7:0]                 nrn_rd_addr,
  input  logic                       nrn_rd_vld,
  output logic                       nrn_rd_rdy,
  output logic signed [CHARGE_W-1:0] nrn_charge,
  output logic                       nrn_charge_vld,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done
);

  localparam int unsigned   AW        = 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_NEURONS - 1);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NUM_NEURONS);
  endfunction

  accum_state_e state;
  logic [AW-1:0] cnt;
  logic          run;

  // Accept stage
  logic          take_rd;
  logic          take_ev;
  logic [AW-1:0] sel_addr;

  // Pipeline register: op registered while the RAM read is in flight
  logic                 p_vld;
  op_kind_e             p_kind;
  logic [AW-1:0]        p_addr;
  logic signed [8:0]    p_charge;
  logic                 p_ok;

  // Last write, used to cover the RAM's read-during-write old-data return
  logic                 lw_vld;
  logic [AW-1:0]        lw_addr;
  logic [CHARGE_W-1:0]  lw_data;

  logic [CHARGE_W-1:0]        ram_q;
  logic signed [CHARGE_W-1:0] old_val;
  logic                       op_wr;
  logic                       sweep_wr;
  logic                       ram_we;
  logic [AW-1:0]              ram_wa;
  logic [CHARGE_W-1:0]        ram_wd;

  assign run        = (state == ST_RUN);
  assign nrn_rd_rdy = run;
  assign dend_rdy   = run && !nrn_rd_vld;
  assign clear_busy = !run;

  assign take_rd  = nrn_rd_vld && run;
  assign take_ev  = dend_vld && dend_rdy;
  assign sel_addr = take_rd ? nrn_rd_addr : dend_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_vld    <= 1'b0;
      p_kind   <= OP_ACC;
      p_addr   <= '0;
      p_charge <= '0;
      p_ok     <= 1'b0;
    end else begin
      p_vld    <= take_rd || take_ev;
      p_kind   <= take_rd ? OP_RD : OP_ACC;
      p_addr   <= sel_addr;
      p_charge <= dend_charge;
      p_ok     <= addr_ok(sel_addr);
    end
  end

  charge_ram #(
    .DEPTH  (NUM_NEURONS),
    .DATA_W (CHARGE_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_wa),
    .wdata (ram_wd),
    .raddr (sel_addr),
    .rdata (ram_q)
  );

  // The sweep waits for the pipe to drain so in-flight ops land first and
  // never compete with it for the write port.
  always_comb begin
    old_val  = (lw_vld && (lw_addr == p_addr)) ? lw_data : ram_q;
    op_wr    = p_vld && p_ok;
    sweep_wr = !run && !p_vld;
    ram_we   = op_wr || sweep_wr;
    ram_wa   = op_wr ? p_addr : cnt;
    ram_wd   = '0;
    if (op_wr && (p_kind == OP_ACC)) begin
      ram_wd = sat_add(old_val, p_charge);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lw_vld  <= 1'b0;
      lw_addr <= '0;
      lw_data <= '0;
    end else if (op_wr) begin
      lw_vld  <= 1'b1;
      lw_addr <= p_addr;
      lw_data <= ram_wd;
    end else if (sweep_wr) begin
      lw_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nrn_charge_vld <= 1'b0;
      nrn_charge     <= '0;
    end else begin
      nrn_charge_vld <= p_vld && (p_kind == OP_RD);
      if (p_vld && (p_kind == OP_RD)) begin
        nrn_charge <= p_ok ? old_val : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      unique case (state)
        ST_CLEAR: begin
          if (sweep_wr) begin
            if (cnt == LAST_ADDR) begin
              state      <= ST_RUN;
              cnt        <= '0;
              clear_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (clear_start) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dendrite_accum.sv
// ---------------------------------------------------------------------------
// tb_dendrite_accum
// Self-checking bench for dendrite_accum: a behavioural charge model applies
// each accepted op in acceptance order and predicts every read strobe two
// cycles later; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_dendrite_accum;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        dend_addr;
  logic signed [8:0] dend_charge;
  logic              dend_vld;
  logic              dend_rdy;
  logic [7:0]        nrn_rd_addr;
  logic              nrn_rd_vld;
  logic              nrn_rd_rdy;
  logic signed [15:0] nrn_charge;
  logic              nrn_charge_vld;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  dendrite_accum #(
    .NUM_NEURONS (256),
    .CHARGE_W    (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dend_addr      (dend_addr),
    .dend_charge    (dend_charge),
    .dend_vld       (dend_vld),
    .dend_rdy       (dend_rdy),
    .nrn_rd_addr    (nrn_rd_addr),
    .nrn_rd_vld     (nrn_rd_vld),
    .nrn_rd_rdy     (nrn_rd_rdy),
    .nrn_charge     (nrn_charge),
    .nrn_charge_vld (nrn_charge_vld),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy),
    .clear_done     (clear_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int strobes  = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int val;
  } exp_t;

  int   model_mem [256];
  exp_t exp_q [$];

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) model_mem[i] = 0;
      exp_q.delete();
    end else begin
      bit   due_now;
      exp_t e;
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("strobe", nrn_charge_vld, due_now);
      if (due_now) begin
        chk("charge", int'(nrn_charge), exp_q[0].val);
        void'(exp_q.pop_front());
      end
      if (nrn_charge_vld) strobes = strobes + 1;
      if (nrn_rd_vld && nrn_rd_rdy) begin
        e.due = cyc + 2;
        e.val = model_mem[nrn_rd_addr];
        exp_q.push_back(e);
        model_mem[nrn_rd_addr] = 0;
      end
      if (dend_vld && dend_rdy) begin
        model_mem[dend_addr] = clamp16(model_mem[dend_addr] + int'(dend_charge));
      end
      if (clear_start && !clear_busy) begin
        for (int i = 0; i < 256; i++) model_mem[i] = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [7:0] a, input int c);
    bit acc;
    acc         = 1'b0;
    dend_addr   = a;
    dend_charge = 9'(c);
    dend_vld    = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = dend_rdy;
      tick();
    end
    dend_vld = 1'b0;
    if (!acc) chk("ev_accept_timeout", 0, 1);
  endtask

  task automatic rd_req(input logic [7:0] a);
    bit acc;
    acc         = 1'b0;
    nrn_rd_addr = a;
    nrn_rd_vld  = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = nrn_rd_rdy;
      tick();
    end
    nrn_rd_vld = 1'b0;
    if (!acc) chk("rd_accept_timeout", 0, 1);
  endtask

  task automatic wait_rd(output int v);
    bit got;
    got = 1'b0;
    v   = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (nrn_charge_vld) begin
        got = 1'b1;
        v   = int'(nrn_charge);
      end
    end
    if (!got) chk("rd_strobe_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_clear(output int busy_n, output int lo_n, output bit done);
    busy_n = 0;
    lo_n   = 0;
    done   = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (clear_done) begin
        done = 1'b1;
        chk("done_cycle_dend_rdy", dend_rdy, 1);
        chk("done_cycle_busy", clear_busy, 0);
      end else begin
        if (clear_busy) busy_n = busy_n + 1;
        if (!dend_rdy)  lo_n   = lo_n + 1;
      end
    end
    if (!done) chk("clear_done_timeout", 0, 1);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dend_rdy"},       dend_rdy, 0);
    chk({tag, "_nrn_rd_rdy"},     nrn_rd_rdy, 0);
    chk({tag, "_nrn_charge"},     int'(nrn_charge), 0);
    chk({tag, "_nrn_charge_vld"}, nrn_charge_vld, 0);
    chk({tag, "_clear_busy"},     clear_busy, 1);
    chk({tag, "_clear_done"},     clear_done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int busy_n;
    int lo_n;
    bit done;
    int v;
    int s0;

    reset_n     = 1'b0;
    dend_addr   = '0;
    dend_charge = '0;
    dend_vld    = 1'b0;
    nrn_rd_addr = '0;
    nrn_rd_vld  = 1'b0;
    clear_start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset_n = 1'b1;
    wait_clear(busy_n, lo_n, done);
    chk("por_rdy_low_cycles", lo_n, 256);
    chk("por_busy_cycles", busy_n, 256);

    rd_req(8'd200);
    wait_rd(v);
    chk("rd200_after_clear", v, 0);

    // Back-to-back events to one neuron, read immediately after.
    send_ev(8'd10, 5);
    send_ev(8'd10, 7);
    send_ev(8'd10, -3);
    rd_req(8'd10);
    wait_rd(v);
    chk("rd10_sum", v, 9);
    rd_req(8'd10);
    wait_rd(v);
    chk("rd10_cleared", v, 0);

    // Saturation both ways.
    for (int i = 0; i < 300; i++) send_ev(8'd3, 127);
    rd_req(8'd3);
    wait_rd(v);
    chk("sat_pos", v, 32767);
    for (int i = 0; i < 300; i++) send_ev(8'd3, -128);
    rd_req(8'd3);
    wait_rd(v);
    chk("sat_neg", v, -32768);

    // Read and event offered together: reads win for four cycles.
    send_ev(8'd21, 4);
    s0          = strobes;
    nrn_rd_addr = 8'd20;
    nrn_rd_vld  = 1'b1;
    dend_addr   = 8'd30;
    dend_charge = 9'sd11;
    dend_vld    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contend_dend_rdy", dend_rdy, 0);
      chk("contend_rd_rdy", nrn_rd_rdy, 1);
      tick();
      nrn_rd_addr = nrn_rd_addr + 8'd1;
    end
    nrn_rd_vld = 1'b0;
    @(negedge clk);
    chk("contend_ev_taken", dend_rdy, 1);
    tick();
    dend_vld = 1'b0;
    repeat (4) tick();
    chk("contend_strobes", strobes - s0, 4);
    rd_req(8'd30);
    wait_rd(v);
    chk("contend_ev_kept", v, 11);

    // Commanded clear.
    send_ev(8'd1, 50);
    send_ev(8'd255, 20);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wait_clear(busy_n, lo_n, done);
    chk("cmd_clear_busy_cycles", busy_n, 256);
    rd_req(8'd1);
    wait_rd(v);
    chk("rd1_after_clear", v, 0);
    rd_req(8'd255);
    wait_rd(v);
    chk("rd255_after_clear", v, 0);

    // Asynchronous reset with a read strobe showing and an event in flight.
    send_ev(8'd40, 9);
    send_ev(8'd40, 9);
    send_ev(8'd40, 9);
    nrn_rd_addr = 8'd40;
    nrn_rd_vld  = 1'b1;
    tick();
    nrn_rd_vld  = 1'b0;
    dend_addr   = 8'd41;
    dend_charge = 9'sd5;
    dend_vld    = 1'b1;
    tick();
    chk("pre_reset_strobe", nrn_charge_vld, 1);
    chk("pre_reset_charge", int'(nrn_charge), 27);
    #1;
    reset_n  = 1'b0;
    #1;
    chk_reset_outputs("mid");
    dend_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_clear(busy_n, lo_n, done);
    chk("mid_rdy_low_cycles", lo_n, 256);
    rd_req(8'd40);
    wait_rd(v);
    chk("rd40_after_reset", v, 0);
    rd_req(8'd41);
    wait_rd(v);
    chk("rd41_after_reset", v, 0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
